gate_controller_param: RTL and testbench

//  Parametrised parking-gate controller; next generation of the gatemanager FSM.
//  - Arrival sensor s01 requests entry.
//  - A PIN entered with a valid strobe opens the gate.
//  - Passage sensor s02 confirms the vehicle went through.
//  New over gatemanager: generic PIN width, configurable attempt limit, open-gate

---
 rtl/gate_controller_param.sv | 175 +++++++++++++++++
 tb/tb_gate_controller_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_controller_param.sv
// Parametrised parking-gate controller.
// A vehicle at the arrival sensor (s01) opens a PIN session. A correct PIN opens
// the gate and the passage sensor (s02) confirms the vehicle went through. Too many
// wrong PINs raise wrong_pin_alarm. Both sensors active together (tailgating)
// raise lock_alarm. The vehicle counter wraps around. Every output is registered,
// so a change in state shows on the outputs right after the clock edge that causes it.
module gate_controller_param #(
    parameter int PIN_W        = 16,
    parameter int MAX_TRIES    = 3,
    parameter int OPEN_TIMEOUT = 32,
    parameter int CNT_W        = 8,
    parameter int TRY_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s01,
    input  logic             s02,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] rghtpss,
    output logic             gate,
    output logic             wrong_pin_alarm,
    output logic             lock_alarm,
    output logic [TRY_W-1:0] try_cnt,
    output logic [CNT_W-1:0] vehicle_cnt,
    output logic [2:0]       state
);

    // The open-gate timer counts from 0 up to OPEN_TIMEOUT-1.
    localparam int TIMER_W = $clog2(OPEN_TIMEOUT);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(OPEN_TIMEOUT - 1);
    localparam logic [TRY_W-1:0]   TRY_LIMIT  = TRY_W'(MAX_TRIES);

    // The encoding is fixed because the state code is visible on the debug port.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PIN = 3'd1,
        OPEN     = 3'd2,
        PASS     = 3'd3,
        ALARM    = 3'd4,
        LOCK     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [CNT_W-1:0]   vehicle_q, vehicle_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               gate_q, gate_d;
    logic               wrong_q, wrong_d;
    logic               lock_q, lock_d;

    // A PIN counts as correct only when every bit matches. No mask is applied.
    logic               pin_ok;
    logic [TRY_W-1:0]   try_inc;

    assign pin_ok  = (pin == rghtpss);
    assign try_inc = try_q + TRY_W'(1);

    // Next-state, counter and registered-output logic.
    always_comb begin
        // NOTE: every variable gets a default before the case statement. A path
        // that leaves a variable unassigned would infer a latch.
        state_d   = state_q;
        try_d     = try_q;
        vehicle_d = vehicle_q;
        timer_d   = timer_q;

        unique case (state_q)
            IDLE: begin
                // PIN strobes have no effect until a vehicle is present.
                if (s01) begin
                    state_d = WAIT_PIN;
                end
            end

            WAIT_PIN: begin
                // A PIN entry wins over the vehicle leaving in the same cycle.
                if (pin_valid) begin
                    if (pin_ok) begin
                        state_d = OPEN;
                        try_d   = '0;
                        timer_d = '0;
                    end else begin
                        try_d = try_inc;
                        if (try_inc == TRY_LIMIT) begin
                            state_d = ALARM;
                        end
                    end
                end else if (!s01) begin
                    state_d = IDLE;
                    try_d   = '0;
                end
            end

            OPEN: begin
                timer_d = timer_q + TIMER_W'(1);
                if (s01 && s02) begin
                    state_d = LOCK;
                end else if (s02) begin
                    // A passage seen on the last timer cycle still counts.
                    state_d = PASS;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                end
            end

            PASS: begin
                if (s01 && s02) begin
                    state_d = LOCK;
                end else if (!s02) begin
                    state_d   = IDLE;
                    vehicle_d = vehicle_q + CNT_W'(1);
                end
            end

            ALARM: begin
                // Wrong PINs are ignored here and try_cnt stays at the limit.
                if (pin_valid && pin_ok) begin
                    state_d = IDLE;
                    try_d   = '0;
                end
            end

            LOCK: begin
                // The sensors are ignored. Only a correct PIN releases the lock.
                if (pin_valid && pin_ok) begin
                    state_d = IDLE;
                end
            end

            default: begin
                // Codes 6 and 7 are unused. Recover to a clean idle session.
                state_d = IDLE;
                try_d   = '0;
            end
        endcase

        // The outputs are decoded from the next state and then registered (Moore).
        gate_d  = (state_d == OPEN) || (state_d == PASS);
        wrong_d = (state_d == ALARM);
        lock_d  = (state_d == LOCK);
    end

    // State, counters and output flops. An asynchronous reset returns all of them to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            try_q     <= '0;
            vehicle_q <= '0;
            timer_q   <= '0;
            gate_q    <= 1'b0;
            wrong_q   <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before the edge.
            state_q   <= state_d;
            try_q     <= try_d;
            vehicle_q <= vehicle_d;
            timer_q   <= timer_d;
            gate_q    <= gate_d;
            wrong_q   <= wrong_d;
            lock_q    <= lock_d;
        end
    end

    assign gate            = gate_q;
    assign wrong_pin_alarm = wrong_q;
    assign lock_alarm      = lock_q;
    assign try_cnt         = try_q;
    assign vehicle_cnt     = vehicle_q;
    assign state           = state_q;

endmodule

// File: tb/tb_gate_controller_param.sv
// Directed bench for gate_controller_param.
// Two instances share all their stimulus: one uses the default parameters and one
// uses CNT_W=2, so the counter wrap can be checked. Inputs change 1 ns after the
// rising edge, and the outputs are sampled at the same point.
module tb_gate_controller_param;

    localparam logic [15:0] GOOD = 16'h4037;
    localparam logic [15:0] BAD  = 16'h1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        s01;
    logic        s02;
    logic        pin_valid;
    logic [15:0] pin;
    logic [15:0] rghtpss;

    logic        gate, wrong_pin_alarm, lock_alarm;
    logic [1:0]  try_cnt;
    logic [7:0]  vehicle_cnt;
    logic [2:0]  state;

    logic        gate_w, wrong_pin_alarm_w, lock_alarm_w;
    logic [1:0]  try_cnt_w;
    logic [1:0]  vehicle_cnt_w;
    logic [2:0]  state_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gate_controller_param dut (
        .clk(clk), .rst(rst), .s01(s01), .s02(s02), .pin_valid(pin_valid),
        .pin(pin), .rghtpss(rghtpss), .gate(gate),
        .wrong_pin_alarm(wrong_pin_alarm), .lock_alarm(lock_alarm),
        .try_cnt(try_cnt), .vehicle_cnt(vehicle_cnt), .state(state)
    );

    gate_controller_param #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .s01(s01), .s02(s02), .pin_valid(pin_valid),
        .pin(pin), .rghtpss(rghtpss), .gate(gate_w),
        .wrong_pin_alarm(wrong_pin_alarm_w), .lock_alarm(lock_alarm_w),
        .try_cnt(try_cnt_w), .vehicle_cnt(vehicle_cnt_w), .state(state_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a 1-cycle PIN strobe.
    task automatic enter_pin(input logic [15:0] value);
        pin       = value;
        pin_valid = 1'b1;
        step();
        pin_valid = 1'b0;
    endtask

    // From IDLE: present a vehicle and enter the correct PIN. s01 stays high.
    task automatic open_gate();
        s01 = 1'b1;
        step();
        enter_pin(GOOD);
    endtask

    initial begin
        rst = 1'b0; s01 = 1'b0; s02 = 1'b0; pin_valid = 1'b0;
        pin = '0; rghtpss = GOOD;
        #3;
        check("reset_state", 32'(state), 32'd0);
        check("reset_gate", 32'(gate), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Test 1: an asynchronous reset in the middle of OPEN.
        open_gate();
        check("t1_open_state", 32'(state), 32'd2);
        check("t1_open_gate", 32'(gate), 32'd1);
        s01 = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t1_rst_gate", 32'(gate), 32'd0);
        check("t1_rst_state", 32'(state), 32'd0);
        check("t1_rst_alarms", 32'({wrong_pin_alarm, lock_alarm}), 32'd0);
        check("t1_rst_try", 32'(try_cnt), 32'd0);
        check("t1_rst_veh", 32'(vehicle_cnt), 32'd0);
        #2 rst = 1'b1;
        step();
        check("t1_after_release", 32'(state), 32'd0);

        // Test 2: a normal pass.
        s01 = 1'b1;
        step();
        check("t2_wait_pin", 32'(state), 32'd1);
        check("t2_gate_closed", 32'(gate), 32'd0);
        enter_pin(GOOD);
        check("t2_gate_open", 32'(gate), 32'd1);
        check("t2_open_state", 32'(state), 32'd2);
        s01 = 1'b0;
        step();
        check("t2_still_open", 32'(gate), 32'd1);
        s02 = 1'b1;
        step();
        check("t2_pass_state", 32'(state), 32'd3);
        check("t2_pass_gate", 32'(gate), 32'd1);
        s02 = 1'b0;
        step();
        check("t2_closed", 32'(gate), 32'd0);
        check("t2_idle", 32'(state), 32'd0);
        check("t2_veh", 32'(vehicle_cnt), 32'd1);

        // Test 3: three wrong PINs, then recovery with the correct PIN.
        s01 = 1'b1;
        step();
        enter_pin(BAD);
        check("t3_try1", 32'(try_cnt), 32'd1);
        check("t3_try1_state", 32'(state), 32'd1);
        enter_pin(BAD);
        check("t3_try2", 32'(try_cnt), 32'd2);
        check("t3_try2_alarm", 32'(wrong_pin_alarm), 32'd0);
        enter_pin(BAD);
        check("t3_try3", 32'(try_cnt), 32'd3);
        check("t3_alarm", 32'(wrong_pin_alarm), 32'd1);
        check("t3_alarm_state", 32'(state), 32'd4);
        check("t3_alarm_gate", 32'(gate), 32'd0);
        enter_pin(BAD);
        check("t3_alarm_hold", 32'(wrong_pin_alarm), 32'd1);
        check("t3_try_hold", 32'(try_cnt), 32'd3);
        enter_pin(GOOD);
        check("t3_clear_state", 32'(state), 32'd0);
        check("t3_clear_alarm", 32'(wrong_pin_alarm), 32'd0);
        check("t3_clear_try", 32'(try_cnt), 32'd0);
        s01 = 1'b0;
        step();

        // When the vehicle leaves during the session, try_cnt is cleared.
        s01 = 1'b1;
        step();
        enter_pin(BAD);
        check("t3b_try1", 32'(try_cnt), 32'd1);
        s01 = 1'b0;
        step();
        check("t3b_idle", 32'(state), 32'd0);
        check("t3b_try_clear", 32'(try_cnt), 32'd0);

        // A PIN strobe wins over s01 falling in the same cycle.
        s01 = 1'b1;
        step();
        s01 = 1'b0;
        enter_pin(GOOD);
        check("t3c_priority", 32'(state), 32'd2);

        // Test 4: the timeout. The gate opened at the previous edge.
        for (int i = 0; i < 31; i++) step();
        check("t4_open_31", 32'(gate), 32'd1);
        step();
        check("t4_closed_32", 32'(gate), 32'd0);
        check("t4_idle", 32'(state), 32'd0);
        check("t4_veh_same", 32'(vehicle_cnt), 32'd1);

        // s02 on the last timer cycle wins over the timeout.
        open_gate();
        s01 = 1'b0;
        for (int i = 0; i < 31; i++) step();
        s02 = 1'b1;
        step();
        check("t4b_pass_wins", 32'(state), 32'd3);
        s02 = 1'b0;
        step();
        check("t4b_veh", 32'(vehicle_cnt), 32'd2);

        // Test 5: tailgating lock.
        open_gate();
        s02 = 1'b1;
        step();
        check("t5_lock_state", 32'(state), 32'd5);
        check("t5_lock_alarm", 32'(lock_alarm), 32'd1);
        check("t5_lock_gate", 32'(gate), 32'd0);
        s01 = 1'b0;
        s02 = 1'b0;
        enter_pin(BAD);
        check("t5_wrong_keeps", 32'(lock_alarm), 32'd1);
        s01 = 1'b1;
        step();
        check("t5_sensors_ignored", 32'(state), 32'd5);
        s01 = 1'b0;
        enter_pin(GOOD);
        check("t5_unlock_state", 32'(state), 32'd0);
        check("t5_unlock_alarm", 32'(lock_alarm), 32'd0);

        // Test 6: reset from IDLE clears the counters. Then the CNT_W=2 instance wraps.
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        check("t6_rst_veh", 32'(vehicle_cnt), 32'd0);
        check("t6_rst_veh_w", 32'(vehicle_cnt_w), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            open_gate();
            s01 = 1'b0;
            s02 = 1'b1;
            step();
            s02 = 1'b0;
            step();
            check($sformatf("t6_veh_w_%0d", i), 32'(vehicle_cnt_w), 32'((i + 1) % 4));
            check($sformatf("t6_veh_%0d", i), 32'(vehicle_cnt), 32'(i + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
